// File: rtl/tc_fifo_queue.sv
// Synchronous FIFO with registered read port, count and full/empty flags.
// Optional sticky overflow/underflow flag `err` enabled by TC_FIFO_ERR_FLAG_EN.
module tc_fifo_queue #(
    parameter int    UUID      = 0,
    parameter string NAME      = "",
    parameter int    BIT_WIDTH = 8,
    parameter int    DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [BIT_WIDTH-1:0]       in,
    output logic [BIT_WIDTH-1:0]       out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
`ifdef TC_FIFO_ERR_FLAG_EN
    output logic                       empty,
    output logic                       err
`else
    output logic                       empty
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Identification parameters carry no hardware; this block never elaborates.
    if ((UUID < 0) && (NAME == "__unused__")) begin : g_id_tag
    end

    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [BIT_WIDTH-1:0] out_q, out_d;
    logic [PW-1:0]        rp_q, rp_d;
    logic [PW-1:0]        wp_q, wp_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign out   = out_q;

    always_comb begin
        push_ok = push && (!full || pop);
        pop_ok  = pop && !empty;
        out_d   = out_q;
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        if (pop_ok) begin
            out_d = mem[rp_q];
            rp_d  = rp_q + PW'(1);
        end
        if (push_ok) begin
            wp_d = wp_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
        end else begin
            out_q   <= out_d;
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately unreset; a push at full+pop overwrites the slot
    // whose old value is read out on the same edge.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp_q] <= in;
        end
    end

`ifdef TC_FIFO_ERR_FLAG_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (push && full && !pop) | (pop && empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_tc_fifo_queue.sv
// Directed + randomized bench for tc_fifo_queue against a queue-based reference model.
module tb_tc_fifo_queue;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         push = 1'b0;
    logic         pop = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;
    logic [2:0]   count;
    logic         full;
    logic         empty;
`ifdef TC_FIFO_ERR_FLAG_EN
    logic         err;
`endif

    int checks = 0;
    int failures = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] out_m = '0;
    logic         err_m = 1'b0;

    tc_fifo_queue #(.UUID(0), .NAME("dut"), .BIT_WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .in    (din),
        .out   (dout),
        .count (count),
        .full  (full),
`ifdef TC_FIFO_ERR_FLAG_EN
        .empty (empty),
        .err   (err)
`else
        .empty (empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"},   32'(dout),  32'(out_m));
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".full"},  32'(full),  32'(mq.size() == D));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
`ifdef TC_FIFO_ERR_FLAG_EN
        chk({tag, ".err"},   32'(err),   32'(err_m));
`endif
    endtask

    task automatic model_reset();
        mq.delete();
        out_m = '0;
        err_m = 1'b0;
    endtask

    // One clock: drive, let the edge happen, update the model, check #1 after.
    task automatic step(input logic p, input logic po, input logic [W-1:0] d, input string tag);
        bit was_full, was_empty;
        push = p;
        pop  = po;
        din  = d;
        @(posedge clk);
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        if ((p && was_full && !po) || (po && was_empty)) err_m = 1'b1;
        if (po && !was_empty) out_m = mq.pop_front();
        if (p && (!was_full || po)) mq.push_back(d);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check_all(tag);
    endtask

    // Reset pulse placed between clock edges.
    task automatic mid_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #12;
        model_reset();
        check_all("reset");
        rst = 1'b0;

        step(1, 0, 8'h11, "rmid_push1");
        step(1, 0, 8'h22, "rmid_push2");
        chk("rmid_count_pre", 32'(count), 32'd2);
        mid_reset("rmid_async");
        chk("rmid_out0", 32'(dout), 32'h0);
        step(0, 1, 8'h00, "rmid_underflow");
        chk("rmid_out_hold", 32'(dout), 32'h0);

        mid_reset("clr1");
        for (int i = 1; i <= 4; i++) step(1, 0, W'(8'hA0 + i), "fill");
        chk("fill_full", 32'(full), 32'd1);
        step(1, 0, 8'hA5, "fill_over");
        chk("fill_over_count", 32'(count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 8'h00, "drain");
            chk("drain_val", 32'(dout), 32'(8'hA0 + i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        mid_reset("clr2");
        for (int i = 1; i <= 4; i++) step(1, 0, W'(8'hB0 + i), "bfill");
        step(1, 1, 8'hB5, "bfull_pp");
        chk("bfull_pp_out", 32'(dout), 32'hB1);
        chk("bfull_pp_count", 32'(count), 32'd4);
        for (int i = 2; i <= 5; i++) begin
            step(0, 1, 8'h00, "bdrain");
            chk("bdrain_val", 32'(dout), 32'(8'hB0 + i));
        end

        step(1, 1, 8'hC1, "cempty_pp");
        chk("cempty_pp_out", 32'(dout), 32'hB5);
        chk("cempty_pp_count", 32'(count), 32'd1);
        step(0, 1, 8'h00, "cpop");
        chk("cpop_out", 32'(dout), 32'hC1);
        chk("cpop_empty", 32'(empty), 32'd1);

        mid_reset("clr3");
        for (int i = 0; i < 10; i++) begin
            step(1, 0, W'(i), "wrap_push");
            step(0, 1, 8'h00, "wrap_pop");
            chk("wrap_val", 32'(dout), 32'(i));
        end

`ifdef TC_FIFO_ERR_FLAG_EN
        mid_reset("clr4");
        step(0, 1, 8'h00, "err_uf");
        chk("err_set", 32'(err), 32'd1);
        step(1, 0, 8'h5A, "err_traffic1");
        step(0, 1, 8'h00, "err_traffic2");
        chk("err_sticky", 32'(err), 32'd1);
        mid_reset("err_clr");
        chk("err_cleared", 32'(err), 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(63) == 0) begin
                mid_reset("rnd_rst");
            end else begin
                step(1'($urandom_range(1)), 1'($urandom_range(1)), W'($urandom), "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
